muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_pkg.sv | 27 ++
 rtl/muldiv_unit.sv | 218 +++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op codes, FSM state encoding and the M-extension funct7 value.
package muldiv_unit_pkg;

    // funct3 encodings of the multiply/divide operations
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // funct7 value that routes an OP-class instruction to this unit
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit. Operands are latched on start, reduced
// to magnitudes, processed one bit per cycle (shift-add multiply or
// restoring divide) and sign-corrected before the result is registered.
// Divide-by-zero and signed overflow bypass the iterative phase.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] srca,
    input  logic [XLEN-1:0] srcb,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int              CW       = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN-1);
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    // Conditional two's-complement negate; -2^(XLEN-1) wraps onto itself,
    // which is exactly its unsigned magnitude.
    function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic en);
        return en ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    // Same for the double-width product, so the high half gets the borrow
    function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic en);
        return en ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    md_state_e          state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [XLEN-1:0]    a_q, a_d;        // raw operand, then magnitude
    logic [XLEN-1:0]    b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;    // product, or {unused, dividend/quotient}
    logic [XLEN-1:0]    rem_q, rem_d;    // divide partial remainder
    logic               neg_q, neg_d;    // result needs negation
    logic               special_q, special_d;
    logic [XLEN-1:0]    spres_q, spres_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic               busy_q, done_q;

    logic               a_signed_s, b_signed_s;
    logic               sgn_a_s, sgn_b_s;
    logic               is_div_s, is_rem_s, div0_s, ovf_s;
    logic [XLEN-1:0]    mag_a_s, mag_b_s;
    logic [XLEN:0]      sum_s;
    logic [XLEN:0]      trial_s;
    logic [2*XLEN-1:0]  prod_s;
    logic [XLEN-1:0]    quo_s, rmd_s;

    // Which operands each operation interprets as signed
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (op_q)
            F3_MUL, F3_MULH, F3_DIV, F3_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            F3_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            F3_MULHU, F3_DIVU, F3_REMU: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
    end

    assign sgn_a_s  = a_signed_s & a_q[XLEN-1];
    assign sgn_b_s  = b_signed_s & b_q[XLEN-1];
    assign mag_a_s  = neg_x(a_q, sgn_a_s);
    assign mag_b_s  = neg_x(b_q, sgn_b_s);
    assign is_div_s = op_q[2];
    assign is_rem_s = op_q[2] & op_q[1];
    assign div0_s   = is_div_s && (b_q == {XLEN{1'b0}});
    assign ovf_s    = is_div_s && !op_q[0] && (a_q == SMIN) && (b_q == {XLEN{1'b1}});

    // One multiply step: add multiplicand when the multiplier LSB is set
    assign sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, a_q} : {(XLEN+1){1'b0}});
    // One restoring-divide step: shift in the next dividend bit, try subtract
    assign trial_s = {rem_q, acc_q[XLEN-1]} - {1'b0, b_q};

    assign prod_s = neg_2x(acc_q, neg_q);
    assign quo_s  = neg_x(acc_q[XLEN-1:0], neg_q);
    assign rmd_s  = neg_x(rem_q, neg_q);

    // Next-state and datapath update for the sequencer
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        neg_d     = neg_q;
        special_d = special_q;
        spres_d   = spres_q;
        res_d     = res_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = funct3;
                    a_d     = srca;
                    b_d     = srcb;
                    state_d = ST_PREP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PREP: begin
                a_d   = mag_a_s;
                b_d   = mag_b_s;
                cnt_d = CNT_LAST;
                rem_d = {XLEN{1'b0}};
                acc_d = is_div_s ? {{XLEN{1'b0}}, mag_a_s} : {{XLEN{1'b0}}, mag_b_s};
                neg_d = is_rem_s ? sgn_a_s : (sgn_a_s ^ sgn_b_s);
                if (div0_s) begin
                    special_d = 1'b1;
                    spres_d   = op_q[1] ? a_q : {XLEN{1'b1}};
                    state_d   = ST_FIX;
                end else if (ovf_s) begin
                    special_d = 1'b1;
                    spres_d   = op_q[1] ? {XLEN{1'b0}} : a_q;
                    state_d   = ST_FIX;
                end else begin
                    special_d = 1'b0;
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                if (!is_div_s) begin
                    acc_d = {sum_s, acc_q[XLEN-1:1]};
                end else if (!trial_s[XLEN]) begin
                    rem_d = trial_s[XLEN-1:0];
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[XLEN-2:0], acc_q[XLEN-1]};
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    state_d = ST_CALC;
                end
            end
            ST_FIX: begin
                if (special_q) begin
                    res_d = spres_q;
                end else if (!is_div_s) begin
                    res_d = (op_q == F3_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
                end else begin
                    res_d = op_q[1] ? rmd_s : quo_s;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            op_q      <= 3'b000;
            a_q       <= {XLEN{1'b0}};
            b_q       <= {XLEN{1'b0}};
            cnt_q     <= {CW{1'b0}};
            acc_q     <= {(2*XLEN){1'b0}};
            rem_q     <= {XLEN{1'b0}};
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            spres_q   <= {XLEN{1'b0}};
            res_q     <= {XLEN{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            spres_q   <= spres_d;
            res_q     <= res_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed XLEN=32 cases with exact cycle timing,
// reset abort, ignored starts, then random XLEN=8 operations compared
// against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rstn;

    logic        start32, busy32, done32;
    logic [2:0]  f3_32;
    logic [31:0] srca32, srcb32, res32;

    logic        start8, busy8, done8;
    logic [2:0]  f3_8;
    logic [7:0]  srca8, srcb8, res8;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32)) u_dut32 (
        .clk(clk), .rstn(rstn), .start(start32), .funct3(f3_32),
        .srca(srca32), .srcb(srcb32), .busy(busy32), .done(done32), .res(res32)
    );

    muldiv_unit #(.XLEN(8)) u_dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .funct3(f3_8),
        .srca(srca8), .srcb(srcb8), .busy(busy8), .done(done8), .res(res8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference for a w-bit unit (w <= 32)
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input int w);
        longint unsigned mask, ua, ub, up;
        longint sa, sb, smin, sp;
        logic [63:0] r;
        bit ovf;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        smin = -(longint'(64'd1) << (w - 1));
        sa   = ua[w-1] ? (longint'(ua) - (longint'(64'd1) << w)) : longint'(ua);
        sb   = ub[w-1] ? (longint'(ub) - (longint'(64'd1) << w)) : longint'(ub);
        ovf  = (sa == smin) && (sb == -64'sd1);
        r    = 64'd0;
        case (op)
            3'b000: begin sp = sa * sb; r = sp; end
            3'b001: begin sp = sa * sb; r = sp; r = r >> w; end
            3'b010: begin sp = sa * longint'(ub); r = sp; r = r >> w; end
            3'b011: begin up = ua * ub; r = up >> w; end
            3'b100: begin
                if (ub == 0) r = mask;
                else if (ovf) r = ua;
                else begin sp = sa / sb; r = sp; end
            end
            3'b101: begin
                if (ub == 0) r = mask;
                else r = ua / ub;
            end
            3'b110: begin
                if (ub == 0) r = ua;
                else if (ovf) r = 64'd0;
                else begin sp = sa % sb; r = sp; end
            end
            default: begin
                if (ub == 0) r = ua;
                else r = ua % ub;
            end
        endcase
        r = r & mask;
        return r[31:0];
    endfunction

    // Divide-by-zero and signed overflow take the short path
    function automatic bit is_short(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input int w);
        longint unsigned mask, ua, ub;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        if (!op[2]) return 1'b0;
        if (ub == 0) return 1'b1;
        if (!op[0] && (ua == (64'd1 << (w - 1))) && (ub == mask)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input int w, input logic s, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w == 32) begin
            start32 = s; f3_32 = op; srca32 = a; srcb32 = b;
        end else begin
            start8 = s; f3_8 = op; srca8 = a[7:0]; srcb8 = b[7:0];
        end
    endtask

    // Start in cycle 0, scramble inputs afterwards, optionally re-pulse start
    // in cycles inj_a/inj_b, and return in the middle of the done cycle.
    task automatic run(input int w, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int exp_cyc,
                       input int inj_a, input int inj_b, input string tag);
        int          done_cyc, ndone, busy_bad;
        logic [31:0] got;
        logic        bz, dn;
        done_cyc = -1; ndone = 0; busy_bad = 0; got = 32'd0;
        @(negedge clk);
        bz = (w == 32) ? busy32 : busy8;
        check({tag, ".idle"}, {63'd0, bz}, 64'd0);
        drive(w, 1'b1, op, a, b);
        for (int c = 1; c <= exp_cyc; c++) begin
            @(negedge clk);
            bz = (w == 32) ? busy32 : busy8;
            dn = (w == 32) ? done32 : done8;
            if (dn) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    got = (w == 32) ? res32 : {24'd0, res8};
                end
            end
            if (bz !== 1'b1) busy_bad++;
            drive(w, (c == inj_a) || (c == inj_b), 3'($urandom), $urandom, $urandom);
        end
        check({tag, ".done_cycle"}, 64'(done_cyc), 64'(exp_cyc));
        check({tag, ".done_count"}, 64'(ndone), 64'd1);
        check({tag, ".busy"}, 64'(busy_bad), 64'd0);
        check({tag, ".res"}, {32'd0, got}, {32'd0, exp_res});
    endtask

    function automatic logic [31:0] pick8();
        case ($urandom_range(0, 6))
            0: return 32'h00;
            1: return 32'h01;
            2: return 32'h80;
            3: return 32'hFF;
            4: return 32'h7F;
            default: return {24'd0, 8'($urandom)};
        endcase
    endfunction

    initial begin
        int          ndone;
        logic [2:0]  op;
        logic [31:0] a, b;

        rstn = 1'b0;
        drive(32, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(8, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (3) @(negedge clk);
        check("rst.busy32", {63'd0, busy32}, 64'd0);
        check("rst.done32", {63'd0, done32}, 64'd0);
        check("rst.res32", {32'd0, res32}, 64'd0);
        check("rst.busy8", {63'd0, busy8}, 64'd0);
        check("rst.done8", {63'd0, done8}, 64'd0);
        check("rst.res8", {56'd0, res8}, 64'd0);
        rstn = 1'b1;

        // Normal path, XLEN=32
        run(32, 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 35, -1, -1, "mul");
        run(32, 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 35, -1, -1, "mulh");
        run(32, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, -1, -1, "mulhsu");
        run(32, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 35, -1, -1, "mulhu");
        run(32, 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 35, -1, -1, "div");
        run(32, 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 35, -1, -1, "rem");
        // Starts in cycles 5 and 35 ignored; start in cycle 36 accepted
        run(32, 3'b101, 32'd100, 32'd7, 32'd14, 35, 5, 35, "divu_inj");
        run(32, 3'b111, 32'd100, 32'd7, 32'd2, 35, -1, -1, "remu_b2b");
        run(32, 3'b110, 32'd7, 32'hFFFFFFFE, 32'd1, 35, -1, -1, "rem_negb");

        // Short path
        run(32, 3'b100, 32'd5, 32'd0, 32'hFFFFFFFF, 3, -1, -1, "div0");
        run(32, 3'b110, 32'd5, 32'd0, 32'd5, 3, -1, -1, "rem0");
        run(32, 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 3, -1, -1, "divu0");
        run(32, 3'b111, 32'd5, 32'd0, 32'd5, 3, -1, -1, "remu0");
        run(32, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 3, -1, -1, "div_ovf");
        run(32, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 3, -1, -1, "rem_ovf");
        run(32, 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 35, -1, -1, "divu_big");

        // Reset in cycle 20 of a DIV abandons it
        @(negedge clk);
        drive(32, 1'b1, 3'b100, 32'd1000, 32'd3);
        ndone = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (done32) ndone++;
            drive(32, 1'b0, 3'b100, $urandom, $urandom);
            if (c == 20) rstn = 1'b0;
        end
        @(negedge clk);
        check("abort.busy", {63'd0, busy32}, 64'd0);
        check("abort.res", {32'd0, res32}, 64'd0);
        rstn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done32) ndone++;
        end
        check("abort.no_done", 64'(ndone), 64'd0);
        run(32, 3'b000, 32'h00012345, 32'h00000010, 32'h00123450, 35, -1, -1, "mul_after_rst");

        // Random operations, XLEN=8
        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick8();
            b  = pick8();
            run(8, op, a, b, ref_model(op, a, b, 8), is_short(op, a, b, 8) ? 3 : 11, -1, -1, "rnd8");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
